// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    GUARD = 2'd2
  } state_e;

  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns, entry [n] is hex digit n
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/display_scan_ctrl_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_c
);

  assign seg_c = HEX_SEG[hex];

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller with guard blanking and
// frame-aligned, tear-free value updates over a valid/ready handshake.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        blank_lz,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  input  logic [3:0]  load_dp,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] ON_LAST   = PW'(REFRESH_DIV - BLANK_CYC - 1);
  localparam logic [PW-1:0] SLOT_LAST = PW'(REFRESH_DIV - 1);

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    dpr_q, dpr_d;
  logic [15:0]   pend_data_q, pend_data_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          pend_full_q, pend_full_d;
  logic          load_ready_q, load_ready_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_tick_q, frame_tick_d;

  logic          frame_end_c;
  logic          commit_c;
  logic          capture_c;
  logic [3:0]    nib_c;
  logic          lz_c;
  logic [6:0]    seg_dec_c;

  // Scan FSM, pending buffer and frame-boundary commit
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    presc_d      = presc_q;
    disp_d       = disp_q;
    dpr_d        = dpr_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_full_d  = pend_full_q;

    frame_end_c  = (state_q == GUARD) && (presc_q == SLOT_LAST) && (idx_q == 2'd3);
    capture_c    = load_valid && load_ready_q;
    commit_c     = pend_full_q && ((state_q == IDLE) || frame_end_c);

    if (commit_c) begin
      disp_d      = pend_data_q;
      dpr_d       = pend_dp_q;
      pend_full_d = 1'b0;
    end else if (capture_c) begin
      pend_data_d = load_data;
      pend_dp_d   = load_dp;
      pend_full_d = 1'b1;
    end

    frame_tick_d = frame_end_c && en;

    if (!en) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ON;
          idx_d   = 2'd0;
          presc_d = '0;
        end
        ON: begin
          presc_d = presc_q + PW'(1);
          if (presc_q == ON_LAST) state_d = GUARD;
        end
        GUARD: begin
          if (presc_q == SLOT_LAST) begin
            state_d = ON;
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = 2'd0;
          presc_d = '0;
        end
      endcase
    end

    load_ready_d = !pend_full_d;
  end

  // Digit nibble and leading-zero blank for the slot being entered
  always_comb begin
    nib_c = 4'h0;
    lz_c  = 1'b0;
    case (idx_d)
      2'd0: nib_c = disp_d[3:0];
      2'd1: begin nib_c = disp_d[7:4];   lz_c = blank_lz && (disp_d[15:4]  == 12'h000); end
      2'd2: begin nib_c = disp_d[11:8];  lz_c = blank_lz && (disp_d[15:8]  == 8'h00);   end
      2'd3: begin nib_c = disp_d[15:12]; lz_c = blank_lz && (disp_d[15:12] == 4'h0);    end
      default: nib_c = 4'h0;
    endcase
  end

  hex_to_seg7 u_dec (
    .hex   (nib_c),
    .seg_c (seg_dec_c)
  );

  // Pin values follow the next state so anode/seg/dp switch together
  always_comb begin
    anode_d = ANODE_OFF;
    seg_d   = SEG_OFF;
    dp_d    = 1'b1;
    if (state_d == ON) begin
      case (idx_d)
        2'd0:    anode_d = 4'b1110;
        2'd1:    anode_d = 4'b1101;
        2'd2:    anode_d = 4'b1011;
        default: anode_d = 4'b0111;
      endcase
      seg_d = lz_c ? SEG_OFF : seg_dec_c;
      dp_d  = ~dpr_d[idx_d];
    end
  end

  // State and data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      presc_q      <= '0;
      disp_q       <= 16'h0000;
      dpr_q        <= 4'h0;
      pend_data_q  <= 16'h0000;
      pend_dp_q    <= 4'h0;
      pend_full_q  <= 1'b0;
      load_ready_q <= 1'b1;
      anode_q      <= ANODE_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      presc_q      <= presc_d;
      disp_q       <= disp_d;
      dpr_q        <= dpr_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_full_q  <= pend_full_d;
      load_ready_q <= load_ready_d;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign load_ready = load_ready_q;
  assign anode      = anode_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule
